pc_prefetch_fetch: RTL and testbench

//  Parametrised instruction-fetch front end: PC register, pipelined requests to a

---
 rtl/pc_prefetch_fetch_pkg.sv | 17 +
 rtl/pc_prefetch_fetch_queue.sv | 72 +++++++
 rtl/pc_prefetch_fetch.sv | 96 +++++++++
 tb/tb_pc_prefetch_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_prefetch_fetch_pkg.sv
// Fetch-stage constants shared with the decode stage: PC stepping, reset vector
// and the opcode field that marks a HALT instruction.
package pc_prefetch_fetch_pkg;

   localparam int          PC_INC_DEF   = 2;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   // Opcode lives in the top OPCODE_W bits of the instruction word.
   localparam int                  OPCODE_W    = 4;
   localparam logic [OPCODE_W-1:0] HALT_OP_DEF = 4'hF;

   function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode,
                                    input logic [OPCODE_W-1:0] halt_op);
      return opcode == halt_op;
   endfunction

endpackage

// File: rtl/pc_prefetch_fetch_queue.sv
// Circular prefetch FIFO holding {pc, instr} pairs; head is always presented
// from registered storage so decode never sees a path from imem_rdata.
module fetch_queue #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_instr,
   input  logic              pop,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_instr,
   output logic [CNT_W-1:0]  count
);

   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   logic [ADDR_W+DATA_W-1:0] entries [DEPTH];

   assign do_push = push & (count_reg != CNT_W'(DEPTH));
   assign do_pop  = pop & (count_reg != '0);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [ADDR_W+DATA_W-1:0] entry_reg;

         // Entries reset to zero so the head reads 0 straight out of reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (do_push && !flush && wr_ptr_reg == PTR_W'(gi)) begin
               entry_reg <= {push_pc, push_instr};
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head_valid = (count_reg != '0);
   assign head_pc    = entries[rd_ptr_reg][ADDR_W+DATA_W-1:DATA_W];
   assign head_instr = entries[rd_ptr_reg][DATA_W-1:0];
   assign count      = count_reg;

endmodule

// File: rtl/pc_prefetch_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding pipelined imem
// requests with credit-based flow control, redirect/flush and HALT detection.
module pc_prefetch_fetch
   import pc_prefetch_fetch_pkg::*;
#(
   parameter int                  ADDR_W   = 16,
   parameter int                  DATA_W   = 16,
   parameter int                  DEPTH    = 4,
   parameter int                  PC_INC   = PC_INC_DEF,
   parameter logic [ADDR_W-1:0]   RESET_PC = RESET_PC_DEF,
   parameter logic [OPCODE_W-1:0] HALT_OP  = HALT_OP_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted
);

   localparam int                CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] req_pc_reg;
   logic              inflight_reg;
   logic              halted_reg;

   logic [CNT_W-1:0]  queue_count;
   logic [CNT_W:0]    occupancy;
   logic              credit;
   logic              issue;
   logic              push;
   logic              pop;
   logic              halt_hit;

   // An outstanding request already owns a slot, so it counts against credit.
   assign occupancy = {1'b0, queue_count} + {{CNT_W{1'b0}}, inflight_reg};
   assign credit    = occupancy < (CNT_W+1)'(DEPTH);
   assign issue     = ~rst & enable & ~halted_reg & ~redirect_valid & credit;

   // A response arriving in a redirect cycle or after HALT is dropped.
   assign push     = inflight_reg & ~halted_reg & ~redirect_valid;
   assign pop      = out_valid & out_ready;
   assign halt_hit = push & is_halt(imem_rdata[DATA_W-1 -: OPCODE_W], HALT_OP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg       <= RESET_PC;
         req_pc_reg   <= '0;
         inflight_reg <= 1'b0;
         halted_reg   <= 1'b0;
      end else if (redirect_valid) begin
         pc_reg       <= redirect_pc;
         inflight_reg <= 1'b0;
         halted_reg   <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            pc_reg     <= pc_reg + PC_STEP;
            req_pc_reg <= pc_reg;
         end
         if (halt_hit) halted_reg <= 1'b1;
      end
   end

   fetch_queue #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_pc    (req_pc_reg),
      .push_instr (imem_rdata),
      .pop        (pop),
      .head_valid (out_valid),
      .head_pc    (out_pc),
      .head_instr (out_instr),
      .count      (queue_count)
   );

   assign imem_req  = issue;
   assign imem_addr = pc_reg;
   assign halted    = halted_reg;

endmodule

// File: tb/tb_pc_prefetch_fetch.sv
// Scoreboard bench for pc_prefetch_fetch: directed stimulus queues expected
// {pc, instr} pairs; a negedge monitor checks every decode handshake.
module tb_pc_prefetch_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        halted;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   xfer_q[$];
   int   cyc = 0;
   int   checks_total = 0;
   int   checks_passed = 0;

   pc_prefetch_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous imem: word {4'h1, addr[11:0]}, except a HALT at 0x000A.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h000A) return 16'hF000;
      return {4'h1, a[11:0]};
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic expect_item(input logic [15:0] pc, input logic [15:0] instr);
      exp_q.push_back({pc, instr});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: scoreboard on every transfer, plus the no-overflow guard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         xfer_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks_total++;
            $display("FAIL unexpected_xfer: got pc %h instr %h expected no transfer", out_pc, out_instr);
         end else begin
            e = exp_q.pop_front();
            check("xfer_pc", out_pc, e.pc);
            check("xfer_instr", out_instr, e.instr);
            $display("xfer cyc=%0d pc=%h instr=%h", cyc, out_pc, out_instr);
         end
      end
      if (!rst && dut.push) check("no_overflow", {31'b0, dut.queue_count < DEPTH}, 1);
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset state, latency and 1/cycle streaming up to HALT at 0x0A
      steps(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_imem_req", imem_req, 0);
      check("rst_halted", halted, 0);
      check("rst_out_pc", out_pc, 16'h0000);
      check("rst_out_instr", out_instr, 16'h0000);
      check("rst_imem_addr", imem_addr, 16'h0000);
      expect_item(16'h0000, 16'h1000);
      expect_item(16'h0002, 16'h1002);
      expect_item(16'h0004, 16'h1004);
      expect_item(16'h0006, 16'h1006);
      expect_item(16'h0008, 16'h1008);
      expect_item(16'h000A, 16'hF000);
      rst = 1'b0;
      #1;
      check("lat_req_cycle0", imem_req, 1);
      step();
      check("lat_valid_before", out_valid, 0);
      step();
      check("lat_valid_cycle1", out_valid, 1);
      wait_drain("t1_drain");
      check("t1_xfer_count", xfer_q.size(), 6);
      if (xfer_q.size() == 6) begin
         for (int i = 1; i < 6; i++) check("t1_rate", xfer_q[i] - xfer_q[i-1], 1);
      end
      steps(2);
      check("t1_halted", halted, 1);
      steps(3);
      check("t1_halt_no_req", imem_req, 0);

      // 2: redirect clears HALT; back-pressure holds exactly DEPTH entries
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0000;
      out_ready      = 1'b0;
      #1;
      check("t2_redir_no_req", imem_req, 0);
      step();
      redirect_valid = 1'b0;
      check("t2_halt_cleared", halted, 0);
      expect_item(16'h0000, 16'h1000);
      expect_item(16'h0002, 16'h1002);
      expect_item(16'h0004, 16'h1004);
      expect_item(16'h0006, 16'h1006);
      expect_item(16'h0008, 16'h1008);
      expect_item(16'h000A, 16'hF000);
      steps(10);
      check("t2_full_count", dut.queue_count, 4);
      check("t2_full_no_req", imem_req, 0);
      check("t2_head_valid", out_valid, 1);
      check("t2_head_pc", out_pc, 16'h0000);
      steps(2);
      check("t2_hold_pc", out_pc, 16'h0000);
      check("t2_hold_instr", out_instr, 16'h1000);
      out_ready = 1'b1;
      wait_drain("t2_drain");
      steps(2);
      check("t2_halted", halted, 1);

      // 3: redirect with queue at credit limit and a response in flight
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0000;
      out_ready      = 1'b0;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!imem_req) break;
      end
      check("t3_pre_count", dut.queue_count, 3);
      check("t3_pre_inflight", dut.inflight_reg, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      #1;
      check("t3_redir_no_req", imem_req, 0);
      step();
      redirect_valid = 1'b0;
      check("t3_flushed", dut.queue_count, 0);
      expect_item(16'h0100, 16'h1100);
      expect_item(16'h0102, 16'h1102);
      expect_item(16'h0104, 16'h1104);
      expect_item(16'h0106, 16'h1106);
      steps(10);
      check("t3_head_pc", out_pc, 16'h0100);
      enable    = 1'b0;
      out_ready = 1'b1;
      wait_drain("t3_drain");

      // 4: redirect in the same cycle as a head handshake
      enable    = 1'b1;
      out_ready = 1'b0;
      steps(10);
      check("t4_full_count", dut.queue_count, 4);
      check("t4_head_pc", out_pc, 16'h0108);
      expect_item(16'h0108, 16'h1108);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0200;
      out_ready      = 1'b1;
      step();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      check("t4_flushed", dut.queue_count, 0);
      check("t4_head_taken_once", exp_q.size(), 0);
      expect_item(16'h0200, 16'h1200);
      expect_item(16'h0202, 16'h1202);
      expect_item(16'h0204, 16'h1204);
      expect_item(16'h0206, 16'h1206);
      steps(10);
      enable    = 1'b0;
      out_ready = 1'b1;
      wait_drain("t4_drain");

      // 6: PC wrap at 0xFFFE, then async reset mid-stream
      out_ready      = 1'b0;
      enable         = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      step();
      redirect_valid = 1'b0;
      expect_item(16'hFFFE, 16'h1FFE);
      expect_item(16'h0000, 16'h1000);
      expect_item(16'h0002, 16'h1002);
      expect_item(16'h0004, 16'h1004);
      steps(10);
      enable    = 1'b0;
      out_ready = 1'b1;
      wait_drain("t6_wrap_drain");
      steps(2);
      check("t6_pc_after_wrap", imem_addr, 16'h0006);
      expect_item(16'h0006, 16'h1006);
      enable = 1'b1;
      steps(3);
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_imem_req", imem_req, 0);
      check("t6_rst_out_pc", out_pc, 16'h0000);
      check("t6_rst_imem_addr", imem_addr, 16'h0000);
      enable = 1'b0;
      step();
      rst = 1'b0;
      steps(2);
      check("end_idle_valid", out_valid, 0);
      check("end_scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
